// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 9-bit ISA.
// Sequences FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module multicycle_control #(
    parameter int MCODEBITS = 9,
    parameter int OPW       = 3,
    parameter int ALUOPW    = 3,
    parameter int MEM_TMO   = 16,
    parameter int CNTW      = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 instr_valid,
    input  logic                 mem_ready,
    input  logic                 zero,
    output logic                 fetch_en,
    output logic                 PCWrite,
    output logic                 Branch,
    output logic                 RegDst,
    output logic                 ALUSrc,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [ALUOPW-1:0]    ALUOp,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNTW-1:0]      retired
);

    localparam int TW = $clog2(MEM_TMO + 1);

    localparam logic [OPW-1:0] OP_AND   = OPW'(3'b000);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(3'b001);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(3'b010);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(3'b011);
    localparam logic [OPW-1:0] OP_LS    = OPW'(3'b100);
    localparam logic [OPW-1:0] OP_RS    = OPW'(3'b101);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(3'b110);
    localparam logic [OPW-1:0] OP_STORE = OPW'(3'b111);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [MCODEBITS-1:0]  r_ir;
    logic [TW-1:0]         r_tmo;
    logic [CNTW-1:0]       r_retired;
    logic                  r_err;

    logic [OPW-1:0]        w_op;
    logic                  w_halt;
    logic                  w_is_bne;
    logic                  w_is_load;
    logic                  w_is_store;
    logic [ALUOPW-1:0]     w_aluop;
    logic                  w_alusrc;
    logic                  w_regdst;

    logic                  w_ir_ld;
    logic                  w_tmo_clr;
    logic                  w_tmo_inc;
    logic                  w_set_err;
    logic                  w_tmo_hit;

    assign w_op       = r_ir[MCODEBITS-1 -: OPW];
    assign w_halt     = &r_ir;
    assign w_is_bne   = (w_op == OP_BNE);
    assign w_is_load  = (w_op == OP_LOAD);
    assign w_is_store = (w_op == OP_STORE);
    assign w_tmo_hit  = (r_tmo == TW'(MEM_TMO - 1));

    // Datapath selects decoded from the latched instruction word
    always_comb begin
        w_aluop  = '0;
        w_alusrc = 1'b0;
        w_regdst = 1'b0;
        case (w_op)
            OP_AND: begin
                w_aluop  = ALUOPW'(3'b000);
                w_regdst = 1'b1;
            end
            OP_ADD: begin
                w_aluop  = ALUOPW'(3'b001);
                w_alusrc = 1'b1;
            end
            OP_XOR: begin
                w_aluop  = ALUOPW'(3'b010);
                w_regdst = 1'b1;
            end
            OP_BNE: begin
                w_aluop  = ALUOPW'(3'b011);
            end
            OP_LS: begin
                w_aluop  = ALUOPW'(3'b011);
                w_alusrc = 1'b1;
            end
            OP_RS: begin
                w_aluop  = ALUOPW'(3'b101);
                w_alusrc = 1'b1;
            end
            OP_LOAD: begin
                w_aluop  = ALUOPW'(3'b110);
                w_alusrc = 1'b1;
            end
            OP_STORE: begin
                w_aluop  = ALUOPW'(3'b111);
                w_alusrc = 1'b1;
            end
            default: begin
                w_aluop  = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ir_ld   = 1'b0;
        w_tmo_clr = 1'b0;
        w_tmo_inc = 1'b0;
        w_set_err = 1'b0;
        fetch_en  = 1'b0;
        PCWrite   = 1'b0;
        Branch    = 1'b0;
        RegDst    = 1'b0;
        ALUSrc    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUOp     = '0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_en = 1'b1;
                if (instr_valid) begin
                    w_ir_ld = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                ALUOp  = w_aluop;
                ALUSrc = w_alusrc;
                RegDst = w_regdst;
                if (w_is_bne) begin
                    PCWrite = 1'b1;
                    Branch  = ~zero;
                    w_next  = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_tmo_clr = 1'b1;
                    w_next    = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                ALUOp    = w_aluop;
                ALUSrc   = w_alusrc;
                RegDst   = w_regdst;
                MemRead  = w_is_load;
                MemWrite = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        PCWrite = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_tmo_hit) begin
                    // Abandon the access: no PC or register update
                    w_set_err = 1'b1;
                    w_next    = S_HALT;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_WB: begin
                ALUOp    = w_aluop;
                ALUSrc   = w_alusrc;
                RegDst   = w_regdst;
                RegWrite = 1'b1;
                MemtoReg = w_is_load;
                PCWrite  = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ir <= '0;
        end else if (w_ir_ld) begin
            r_ir <= instr;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tmo <= '0;
        end else if (w_tmo_clr) begin
            r_tmo <= '0;
        end else if (w_tmo_inc) begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Every retirement coincides with the single PCWrite pulse
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_retired <= '0;
        end else if (PCWrite) begin
            r_retired <= r_retired + CNTW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end
    end

    assign busy    = (r_state != S_IDLE) && (r_state != S_HALT);
    assign err     = r_err;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction stream,
// expected retire/halt events queued by stimulus and checked by a monitor.
module tb_multicycle_control;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] instr = '0;
    logic       instr_valid = 1'b0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;

    logic       fetch_en, PCWrite, Branch, RegDst, ALUSrc, MemtoReg;
    logic       RegWrite, MemRead, MemWrite, busy, done, err;
    logic [2:0] ALUOp;
    logic [3:0] retired;

    multicycle_control #(
        .MCODEBITS(9), .OPW(3), .ALUOPW(3), .MEM_TMO(16), .CNTW(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .instr(instr),
        .instr_valid(instr_valid), .mem_ready(mem_ready), .zero(zero),
        .fetch_en(fetch_en), .PCWrite(PCWrite), .Branch(Branch),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUOp(ALUOp), .busy(busy), .done(done), .err(err),
        .retired(retired)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         kind;   // 0 = retire (PCWrite), 1 = halt entry
        logic [8:0] vec;    // {Branch,RegWrite,MemtoReg,MemWrite,RegDst,ALUSrc,ALUOp}
        logic [8:0] mask;
        logic [3:0] ret;
        logic       er;
    } exp_t;

    exp_t       sbq[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic [3:0] exp_ret = '0;
    int         mc = 0;
    logic       prev_done = 1'b0;

    localparam logic [8:0] M_ALL = 9'h1FF;
    localparam logic [8:0] M_NOSEL = 9'h1E7;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_ret(input logic [8:0] vec, input logic [8:0] mask);
        sbq.push_back('{kind: 1'b0, vec: vec, mask: mask, ret: exp_ret, er: 1'b0});
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic push_halt(input logic er);
        sbq.push_back('{kind: 1'b1, vec: 9'h0, mask: 9'h0, ret: exp_ret, er: er});
    endtask

    // Feed one instruction; mdly = MEM cycle on which mem_ready rises (0 = never)
    task automatic run_instr(input logic [8:0] ins, input logic z, input int mdly);
        int g;
        instr = ins;
        zero = z;
        mem_ready = 1'b0;
        mc = 0;
        g = 0;
        while (!fetch_en && g < 50) begin
            step();
            g++;
        end
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        g = 0;
        while (!fetch_en && !done && g < 60) begin
            if (MemRead || MemWrite) begin
                mc++;
                mem_ready = (mdly > 0) && (mc == mdly);
            end else begin
                mem_ready = 1'b0;
            end
            step();
            g++;
        end
        mem_ready = 1'b0;
        if (g >= 60) begin
            n_chk++;
            $display("FAIL run_timeout: instr %0h never completed", ins);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Reset) begin
            prev_done = 1'b0;
        end else begin
            if (PCWrite) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_retire: retired=%0d", retired);
                end else begin
                    e = sbq.pop_front();
                    chk("event_kind_retire", 32'(e.kind), 32'(0));
                    chk("retire_sel",
                        32'({Branch, RegWrite, MemtoReg, MemWrite, RegDst,
                             ALUSrc, ALUOp} & e.mask),
                        32'(e.vec & e.mask));
                    chk("retire_cnt", 32'(retired), 32'(e.ret));
                end
            end
            if (done && !prev_done) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_halt: err=%0d", err);
                end else begin
                    e = sbq.pop_front();
                    chk("event_kind_halt", 32'(e.kind), 32'(1));
                    chk("halt_err", 32'(err), 32'(e.er));
                    chk("halt_cnt", 32'(retired), 32'(e.ret));
                    chk("halt_strobes",
                        32'({PCWrite, RegWrite, MemRead, MemWrite, busy}), 32'(0));
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #2;
        chk("reset_outs",
            32'({fetch_en, PCWrite, Branch, RegDst, ALUSrc, MemtoReg, RegWrite,
                 MemRead, MemWrite, ALUOp, busy, done, err}), 32'(0));
        chk("reset_retired", 32'(retired), 32'(0));
        step();
        Reset = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'(0));

        pulse_start();
        chk("start_fetch", 32'(fetch_en), 32'(1));

        push_ret(9'b0_1_0_0_0_1_001, M_ALL);
        run_instr(9'b001_000_011, 1'b0, 0);
        chk("add_retired", 32'(retired), 32'(1));

        push_ret(9'b0_1_0_0_1_0_000, M_ALL);
        run_instr(9'b000_001_010, 1'b0, 0);
        push_ret(9'b0_1_0_0_1_0_010, M_ALL);
        run_instr(9'b010_011_100, 1'b0, 0);
        push_ret(9'b0_1_0_0_0_1_011, M_ALL);
        run_instr(9'b100_001_001, 1'b0, 0);
        push_ret(9'b0_1_0_0_0_1_101, M_ALL);
        run_instr(9'b101_010_010, 1'b0, 0);

        push_ret(9'b1_0_0_0_0_0_011, M_NOSEL);
        run_instr(9'b011_001_010, 1'b0, 0);
        push_ret(9'b0_0_0_0_0_0_011, M_NOSEL);
        run_instr(9'b011_001_010, 1'b1, 0);

        push_ret(9'b0_0_0_1_0_0_111, M_NOSEL);
        run_instr(9'b111_001_000, 1'b0, 1);
        chk("store_mem_cycles", 32'(mc), 32'(1));

        push_ret(9'b0_1_1_0_0_0_110, M_NOSEL);
        run_instr(9'b110_010_001, 1'b0, 3);
        chk("load_memread_cycles", 32'(mc), 32'(3));

        push_halt(1'b0);
        run_instr(9'b111_111_111, 1'b0, 0);
        chk("halt_done", 32'({done, busy}), 32'(2'b10));
        pulse_start();
        chk("halt_restart", 32'({fetch_en, done}), 32'(2'b10));

        for (int i = 0; i < 7; i++) begin
            push_ret(9'b0_1_0_0_0_1_001, M_ALL);
            run_instr(9'b001_000_011, 1'b0, 0);
        end
        chk("retired_wrap", 32'(retired), 32'(exp_ret));
        chk("retired_wrap_zero", 32'(retired), 32'(0));

        push_halt(1'b1);
        run_instr(9'b111_010_001, 1'b0, 0);
        chk("tmo_mem_cycles", 32'(mc), 32'(16));
        chk("tmo_state", 32'({err, done, MemWrite, PCWrite}), 32'(4'b1100));
        chk("tmo_retired", 32'(retired), 32'(exp_ret));
        pulse_start();
        chk("err_sticky", 32'({err, fetch_en}), 32'(2'b11));

        instr = 9'b110_001_001;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        chk("pre_reset_memread", 32'(MemRead), 32'(1));
        Reset = 1'b1;
        #1;
        chk("async_reset_outs",
            32'({fetch_en, PCWrite, Branch, RegDst, ALUSrc, MemtoReg, RegWrite,
                 MemRead, MemWrite, ALUOp, busy, done, err}), 32'(0));
        chk("async_reset_retired", 32'(retired), 32'(0));
        step();
        Reset = 1'b0;
        step();
        chk("post_reset_idle", 32'({busy, fetch_en, done, err}), 32'(0));
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
